// File: rtl/qs_partition.sv
`default_nettype none
// ============================================================================
//  Module   : qs_partition
//  Purpose  : Sequential Lomuto quicksort partition engine over a local array
//             of sign-magnitude floats. One pass partitions [lo,hi] around
//             pivot = element[hi], one element per cycle.
//  Options  : QS_SWAP_CNT_EN adds a swap_cnt output counting real swaps.
//  Revision : 1.0  initial release
// ============================================================================
module qs_partition #(
    parameter int N     = 23,
    parameter int M     = 8,
    parameter int L     = N + M + 1,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [L-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [L-1:0]  rd_data,
    input  logic          start,
    input  logic [AW-1:0] lo,
    input  logic [AW-1:0] hi,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pivot_idx,
`ifdef QS_SWAP_CNT_EN
    output logic [AW:0]   swap_cnt,
`endif
    output logic          err
);

    // Array index width; all in-range indices fit in this many bits.
    localparam int          c_iw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] c_depth = (AW + 1)'(DEPTH);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_scan  = 2'd1;
    localparam logic [1:0] c_place = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    logic [L-1:0]  r_mem [DEPTH];
    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic [AW-1:0] r_i;
    logic [AW-1:0] r_j;
    logic [AW-1:0] r_hi;
    logic [AW-1:0] r_pidx;
    logic [L-1:0]  r_pivot;
    logic [L-1:0]  r_rd;
    logic          r_err;

    logic          w_hi_bad;
    logic          w_degen;
    logic          w_accept;
    logic          w_last;
    logic [L-1:0]  w_a;
    logic          w_gt;

    // Sign-magnitude ordering: positive beats negative; otherwise compare the
    // raw magnitude field, so a larger negative magnitude also counts greater.
    function automatic logic f_greater(input logic [L-1:0] a, input logic [L-1:0] b);
        if (a[L-1] != b[L-1]) return ~a[L-1];
        return a[L-2:0] > b[L-2:0];
    endfunction

    assign w_hi_bad = ({1'b0, hi} >= c_depth);
    assign w_degen  = (lo >= hi);
    assign w_accept = (r_state == c_idle) && start && !w_hi_bad;
    assign w_last   = (r_j == r_hi - 1'b1);
    assign w_a      = r_mem[r_j[c_iw-1:0]];
    assign w_gt     = f_greater(w_a, r_pivot);

    assign busy      = (r_state == c_scan) || (r_state == c_place);
    assign done      = (r_state == c_done);
    assign pivot_idx = r_pidx;
    assign rd_data   = r_rd;
    assign err       = r_err;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_idle;
        else     r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle:  if (w_accept) w_next = w_degen ? c_done : c_scan;
            c_scan:  if (w_last)   w_next = c_place;
            c_place: w_next = c_done;
            default: w_next = c_idle;
        endcase
    end

    // Array, pass indices, read port and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_hi    <= '0;
            r_pidx  <= '0;
            r_pivot <= '0;
            r_rd    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= (r_state == c_idle) && start && w_hi_bad;
            r_rd  <= ({1'b0, rd_addr} < c_depth) ? r_mem[rd_addr[c_iw-1:0]] : '0;
            case (r_state)
                c_idle: begin
                    if (wr_en && ({1'b0, wr_addr} < c_depth))
                        r_mem[wr_addr[c_iw-1:0]] <= wr_data;
                    if (w_accept) begin
                        if (w_degen) begin
                            r_pidx <= lo;
                        end else begin
                            r_hi    <= hi;
                            r_pivot <= r_mem[hi[c_iw-1:0]];
                            r_i     <= lo;
                            r_j     <= lo;
                        end
                    end
                end
                c_scan: begin
                    // When i == j both writes carry the same value.
                    if (!w_gt) begin
                        r_mem[r_i[c_iw-1:0]] <= w_a;
                        r_mem[r_j[c_iw-1:0]] <= r_mem[r_i[c_iw-1:0]];
                        r_i <= r_i + 1'b1;
                    end
                    r_j <= r_j + 1'b1;
                end
                c_place: begin
                    r_mem[r_i[c_iw-1:0]]  <= r_mem[r_hi[c_iw-1:0]];
                    r_mem[r_hi[c_iw-1:0]] <= r_mem[r_i[c_iw-1:0]];
                    r_pidx <= r_i;
                end
                default: ;
            endcase
        end
    end

`ifdef QS_SWAP_CNT_EN
    logic [AW:0] r_swap_cnt;

    // Counts swaps that actually move data; cleared by each accepted start.
    always_ff @(posedge clk) begin
        if (rst || w_accept)
            r_swap_cnt <= '0;
        else if ((r_state == c_scan) && !w_gt && (r_i != r_j))
            r_swap_cnt <= r_swap_cnt + 1'b1;
        else if ((r_state == c_place) && (r_i != r_hi))
            r_swap_cnt <= r_swap_cnt + 1'b1;
    end

    assign swap_cnt = r_swap_cnt;
`endif

endmodule
`default_nettype wire
